uart_rx_core: RTL and testbench

Serial receive engine for the UART peripheral. It synchronises the asynchronous `uart_rx` pin and detects 8N1 frames (one start bit, 8 data bits LSB first, one stop bit). Each completed byte is delivered to the UART register block as `rx_data_o` plus a one-cycle `rx_over_o` pulse, which the register block latches into its RX register and RX-full status bit. The block sits between the pad and the memory-mapped UART register file, directly upstream of it.

---
 rtl/uart_rx_core_if.sv | 33 +++
 rtl/uart_rx_core.sv | 142 ++++++++++++++
 tb/tb_uart_rx_core.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// Signal bundle between the UART receive engine and the UART register block.
// The register block (master) drives control and the pin; the engine (slave) returns data and status.
interface uart_rx_core_if #(
    parameter int unsigned BAUD_W = 32
);
    logic              rx_en_i;
    logic [BAUD_W-1:0] baud_div_i;
    logic              uart_rx_i;
    logic [7:0]        rx_data_o;
    logic              rx_over_o;
    logic              frame_err_o;
    logic              busy_o;

    modport master (
        output rx_en_i,
        output baud_div_i,
        output uart_rx_i,
        input  rx_data_o,
        input  rx_over_o,
        input  frame_err_o,
        input  busy_o
    );

    modport slave (
        input  rx_en_i,
        input  baud_div_i,
        input  uart_rx_i,
        output rx_data_o,
        output rx_over_o,
        output frame_err_o,
        output busy_o
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receive engine: pin synchroniser, start-edge detect, mid-bit sampling FSM.
// Delivers each good byte with a one-cycle rx_over_o pulse; bad stop bits give frame_err_o.
module uart_rx_core #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned BAUD_W      = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_rx_core_if.slave bus
);
    localparam logic [BAUD_W-1:0] MIN_DIV = BAUD_W'(4);
    localparam logic [BAUD_W-1:0] ONE     = BAUD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_d;
    state_t                 r_state;
    logic [BAUD_W-1:0]      r_div;
    logic [BAUD_W-1:0]      r_half;
    logic [BAUD_W-1:0]      r_cnt;
    logic [2:0]             r_bit;
    logic [7:0]             r_shift;
    logic [7:0]             r_data;
    logic                   r_over;
    logic                   r_ferr;
    logic                   r_busy;

    logic                   w_rxs;
    logic                   w_fall;
    logic [BAUD_W-1:0]      w_div_clamped;
    logic [BAUD_W-1:0]      w_limit;
    logic                   w_tick;

    // Synchroniser and its delayed copy idle at 1 so reset never fakes a start edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync  <= '1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.uart_rx_i};
            r_rxs_d <= w_rxs;
        end
    end

    assign w_rxs         = r_sync[SYNC_STAGES-1];
    assign w_fall        = r_rxs_d & ~w_rxs;
    assign w_div_clamped = (bus.baud_div_i < MIN_DIV) ? MIN_DIV : bus.baud_div_i;
    assign w_limit       = (r_state == S_START) ? r_half : r_div;
    assign w_tick        = (r_cnt == (w_limit - ONE));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_div   <= MIN_DIV;
            r_half  <= MIN_DIV >> 1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_over  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // NOTE: pulses default low here so each one lasts exactly one cycle.
            r_over <= 1'b0;
            r_ferr <= 1'b0;
            if (r_state != S_IDLE && !bus.rx_en_i) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.rx_en_i && w_fall) begin
                            r_div   <= w_div_clamped;
                            r_half  <= w_div_clamped >> 1;
                            r_cnt   <= '0;
                            r_bit   <= '0;
                            r_state <= S_START;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (w_tick) begin
                            r_cnt <= '0;
                            if (w_rxs) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end
                    S_DATA: begin
                        if (w_tick) begin
                            r_cnt   <= '0;
                            r_shift <= {w_rxs, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end
                    S_STOP: begin
                        if (w_tick) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            if (w_rxs) begin
                                r_data <= r_shift;
                                r_over <= 1'b1;
                            end else begin
                                r_ferr <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data_o   = r_data;
    assign bus.rx_over_o   = r_over;
    assign bus.frame_err_o = r_ferr;
    assign bus.busy_o      = r_busy;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: framing, timing, glitch, frame error, enable, divisor and reset cases.
// Expected cycles use pulse = start + 2 (sync) + H + 9*D + 1, with start = cycle the pin falls.
module tb_uart_rx_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_tests = 0;
    int n_fail  = 0;

    int   over_cyc[$];
    logic [7:0] over_data[$];
    int   ferr_cyc[$];
    int   busy_rise[$];
    int   busy_fall[$];
    int   both_cnt = 0;
    logic busy_prev = 1'b0;

    uart_rx_core_if #(.BAUD_W(32)) bus ();

    uart_rx_core #(
        .SYNC_STAGES(2),
        .BAUD_W     (32)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_over_o) begin
            over_cyc.push_back(cyc);
            over_data.push_back(bus.rx_data_o);
        end
        if (bus.frame_err_o) ferr_cyc.push_back(cyc);
        if (bus.rx_over_o && bus.frame_err_o) both_cnt++;
        if (bus.busy_o && !busy_prev) busy_rise.push_back(cyc);
        if (!bus.busy_o && busy_prev) busy_fall.push_back(cyc);
        busy_prev = bus.busy_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int oc(input int i);
        return (i < over_cyc.size()) ? over_cyc[i] : -1;
    endfunction

    function automatic logic [7:0] od(input int i);
        return (i < over_data.size()) ? over_data[i] : 8'hxx;
    endfunction

    function automatic int fc(input int i);
        return (i < ferr_cyc.size()) ? ferr_cyc[i] : -1;
    endfunction

    function automatic int br(input int i);
        return (i < busy_rise.size()) ? busy_rise[i] : -1;
    endfunction

    function automatic int bf(input int i);
        return (i < busy_fall.size()) ? busy_fall[i] : -1;
    endfunction

    task automatic clear_mon();
        over_cyc.delete();
        over_data.delete();
        ferr_cyc.delete();
        busy_rise.delete();
        busy_fall.delete();
    endtask

    // All drive tasks start and end at posedge + 1 time unit.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        bus.uart_rx_i = v;
        idle(n);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) idle(1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int d);
        logic [7:0] bits;
        bits = b;
        drive_bit(1'b0, d);
        for (int i = 0; i < 8; i++) drive_bit(bits[i], d);
        drive_bit(stop_v, d);
    endtask

    initial begin
        int s;
        bus.rx_en_i    = 1'b0;
        bus.baud_div_i = 32'd16;
        bus.uart_rx_i  = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);

        // Reset state
        check("rst_data", {24'd0, bus.rx_data_o}, 32'h00);
        check("rst_over", {31'd0, bus.rx_over_o}, 32'd0);
        check("rst_ferr", {31'd0, bus.frame_err_o}, 32'd0);
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);

        bus.rx_en_i = 1'b1;
        idle(5);

        // Good frame 0x55, D=16
        clear_mon();
        s = cyc;
        send_frame(8'h55, 1'b1, 16);
        idle(4);
        check("good_n", over_cyc.size(), 32'd1);
        check("good_cyc", oc(0), s + 155);
        check("good_data", {24'd0, od(0)}, 32'h55);
        check("good_ferr", ferr_cyc.size(), 32'd0);
        check("good_busy_rise", br(0), s + 3);
        check("good_busy_fall", bf(0), s + 155);

        // Back-to-back 0x00 then 0xFF
        clear_mon();
        s = cyc;
        send_frame(8'h00, 1'b1, 16);
        send_frame(8'hFF, 1'b1, 16);
        idle(4);
        check("b2b_n", over_cyc.size(), 32'd2);
        check("b2b_cyc0", oc(0), s + 155);
        check("b2b_gap", oc(1) - oc(0), 32'd160);
        check("b2b_d0", {24'd0, od(0)}, 32'h00);
        check("b2b_d1", {24'd0, od(1)}, 32'hFF);

        // Glitch of 4 cycles
        clear_mon();
        s = cyc;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 30);
        check("glitch_rise", br(0), s + 3);
        check("glitch_fall", bf(0), s + 11);
        check("glitch_pulses", over_cyc.size() + ferr_cyc.size(), 32'd0);
        check("glitch_busy", {31'd0, bus.busy_o}, 32'd0);
        check("glitch_data", {24'd0, bus.rx_data_o}, 32'hFF);

        // Frame error 0xA3, line then held low as a break
        clear_mon();
        s = cyc;
        send_frame(8'hA3, 1'b0, 16);
        drive_bit(1'b0, 40);
        check("ferr_n", ferr_cyc.size(), 32'd1);
        check("ferr_cyc", fc(0), s + 155);
        check("ferr_over", over_cyc.size(), 32'd0);
        check("ferr_data", {24'd0, bus.rx_data_o}, 32'hFF);
        check("ferr_break_busy", {31'd0, bus.busy_o}, 32'd0);
        drive_bit(1'b1, 16);
        clear_mon();
        send_frame(8'h3C, 1'b1, 16);
        idle(4);
        check("after_ferr_n", over_cyc.size(), 32'd1);
        check("after_ferr_data", {24'd0, od(0)}, 32'h3C);
        check("after_ferr_ferr", ferr_cyc.size(), 32'd0);

        // Enable dropped during data bit 3
        clear_mon();
        s = cyc;
        fork
            send_frame(8'h5A, 1'b1, 16);
            begin
                wait_cyc(s + 74);
                check("en_busy_before", {31'd0, bus.busy_o}, 32'd1);
                bus.rx_en_i = 1'b0;
                idle(1);
                check("en_busy_after", {31'd0, bus.busy_o}, 32'd0);
            end
        join
        idle(4);
        bus.rx_en_i = 1'b1;
        idle(20);
        check("en_pulses", over_cyc.size() + ferr_cyc.size(), 32'd0);
        check("en_data", {24'd0, bus.rx_data_o}, 32'h3C);

        // Divisor 2 clamps to 4: H=2, pulse at s+2+2+36+1
        clear_mon();
        bus.baud_div_i = 32'd2;
        s = cyc;
        send_frame(8'hC6, 1'b1, 4);
        idle(4);
        check("clamp_n", over_cyc.size(), 32'd1);
        check("clamp_cyc", oc(0), s + 41);
        check("clamp_data", {24'd0, od(0)}, 32'hC6);

        // Divisor changed 16 -> 32 mid-frame is ignored
        clear_mon();
        bus.baud_div_i = 32'd16;
        idle(2);
        s = cyc;
        fork
            send_frame(8'h96, 1'b1, 16);
            begin
                wait_cyc(s + 50);
                bus.baud_div_i = 32'd32;
            end
        join
        idle(4);
        check("latch_n", over_cyc.size(), 32'd1);
        check("latch_cyc", oc(0), s + 155);
        check("latch_data", {24'd0, od(0)}, 32'h96);
        bus.baud_div_i = 32'd16;
        idle(2);

        // Reset during data bit 5 of 0xE0 (line stays high from bit 5 on)
        clear_mon();
        s = cyc;
        fork
            send_frame(8'hE0, 1'b1, 16);
            begin
                wait_cyc(s + 104);
                check("rstmid_busy_before", {31'd0, bus.busy_o}, 32'd1);
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
                check("rstmid_data", {24'd0, bus.rx_data_o}, 32'h00);
                check("rstmid_busy", {31'd0, bus.busy_o}, 32'd0);
                check("rstmid_over", {31'd0, bus.rx_over_o}, 32'd0);
                check("rstmid_ferr", {31'd0, bus.frame_err_o}, 32'd0);
            end
        join
        idle(10);
        check("rstmid_pulses", over_cyc.size() + ferr_cyc.size(), 32'd0);
        clear_mon();
        s = cyc;
        send_frame(8'h81, 1'b1, 16);
        idle(4);
        check("post_rst_n", over_cyc.size(), 32'd1);
        check("post_rst_cyc", oc(0), s + 155);
        check("post_rst_data", {24'd0, od(0)}, 32'h81);

        check("pulse_exclusive", both_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
